// File: rtl/mem_interconnect_nport.sv
// Single-master to N-target data-memory interconnect: base/mask decode, one outstanding transaction.
// Optional watchdog and sticky dead-target tracking when MEM_IC_TIMEOUT_EN is defined.
module mem_interconnect_nport #(
  parameter int XLEN        = 32,
  parameter int NUM_TGT     = 4,
  parameter logic [NUM_TGT*XLEN-1:0] TGT_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*XLEN-1:0] TGT_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    core_clk_i,
  input  logic                    core_resetn_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [XLEN-1:0]         req_addr_i,
  input  logic                    req_write_i,
  input  logic [XLEN-1:0]         req_wdata_i,
  input  logic [XLEN/8-1:0]       req_strb_i,
  output logic                    rsp_valid_o,
  output logic [XLEN-1:0]         rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NUM_TGT-1:0]      tgt_valid_o,
  input  logic [NUM_TGT-1:0]      tgt_ready_i,
  output logic [XLEN-1:0]         tgt_addr_o,
  output logic                    tgt_write_o,
  output logic [XLEN-1:0]         tgt_wdata_o,
  output logic [XLEN/8-1:0]       tgt_strb_o,
  input  logic [NUM_TGT-1:0]      tgt_rsp_valid_i,
  input  logic [NUM_TGT*XLEN-1:0] tgt_rdata_i,
  input  logic [NUM_TGT-1:0]      tgt_err_i,
  output logic [15:0]             err_count_o
);

  localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]         state;
  logic [SEL_W-1:0]   sel_q;
  logic [XLEN-1:0]    addr_q;
  logic               write_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN/8-1:0]  strb_q;
  logic [XLEN-1:0]    rdata_q;
  logic               err_q;
  logic [15:0]        err_count;

  logic               dec_hit;
  logic               dec_dead;
  logic [SEL_W-1:0]   dec_sel;
  logic               sel_ready;
  logic               sel_rsp;
  logic               sel_err;
  logic [XLEN-1:0]    sel_rdata;
  logic [NUM_TGT-1:0] sel_onehot;
  logic               tmo_hit;
  logic [NUM_TGT-1:0] dead;

  // Descending scan so the lowest-index matching target wins on overlapping windows.
  always_comb begin
    dec_hit  = 1'b0;
    dec_dead = 1'b0;
    dec_sel  = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((req_addr_i & TGT_MASK[i*XLEN +: XLEN]) == TGT_BASE[i*XLEN +: XLEN]) begin
        dec_hit  = 1'b1;
        dec_dead = dead[i];
        dec_sel  = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_ready  = 1'b0;
    sel_rsp    = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready     = tgt_ready_i[i];
        sel_rsp       = tgt_rsp_valid_i[i];
        sel_err       = tgt_err_i[i];
        sel_rdata     = tgt_rdata_i[i*XLEN +: XLEN];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef MEM_IC_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // A handshake or response in the final cycle takes priority over the watchdog.
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYC - 1)) &&
                   (((state == REQ) && !sel_ready) || ((state == WAIT) && !sel_rsp));

  always_ff @(posedge core_clk_i or negedge core_resetn_i) begin
    if (!core_resetn_i) begin
      tmo_cnt <= '0;
      dead    <= '0;
    end else begin
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if ((state == REQ) || (state == WAIT)) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (tmo_hit) begin
        dead <= dead | sel_onehot;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign dead    = '0;
`endif

  always_ff @(posedge core_clk_i or negedge core_resetn_i) begin
    if (!core_resetn_i) begin
      state   <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
            strb_q  <= req_strb_i;
            sel_q   <= dec_sel;
            rdata_q <= '0;
            if (!dec_hit || dec_dead) begin
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              err_q <= 1'b0;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (sel_ready) begin
            if (sel_rsp) begin
              rdata_q <= sel_rdata;
              err_q   <= sel_err;
              state   <= RESP;
            end else begin
              state <= WAIT;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        WAIT: begin
          if (sel_rsp) begin
            rdata_q <= sel_rdata;
            err_q   <= sel_err;
            state   <= RESP;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk_i or negedge core_resetn_i) begin
    if (!core_resetn_i) begin
      err_count <= '0;
    end else if ((state == RESP) && err_q && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign req_ready_o = (state == IDLE);
  assign tgt_valid_o = (state == REQ) ? sel_onehot : '0;
  assign tgt_addr_o  = addr_q;
  assign tgt_write_o = write_q;
  assign tgt_wdata_o = wdata_q;
  assign tgt_strb_o  = strb_q;
  assign rsp_valid_o = (state == RESP);
  assign rsp_err_o   = (state == RESP) && err_q;
  // Read data only escapes on a clean read response.
  assign rsp_rdata_o = ((state == RESP) && !err_q && !write_q) ? rdata_q : '0;
  assign err_count_o = err_count;

endmodule
